instr_fetch_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline register of the RISC-V core. Owns the PC,

---
 rtl/instr_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, runs one-outstanding valid/ready
// instruction fetches, and handles stalls, flushes and redirects. Optional counters: FETCH_PERF_CNT_EN.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] InstrCount,
    output logic [31:0] StallCount
`endif
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] hold_data;
    logic            drop;

    logic [XLEN-1:0] pc_target_c;
    logic            handshake_c;
    logic            load_c;
    logic [XLEN-1:0] load_data_c;

    // Redirect targets are always word aligned.
    assign pc_target_c  = PCTargetE & ~XLEN'(3);

    assign ImemReqValid = (state == S_REQ) && !PCSrcE && !reset;
    assign ImemAddr     = pcf;
    assign handshake_c  = ImemReqValid && ImemReqReady;

    // A word reaches IF/ID either straight from memory or from the hold buffer.
    assign load_c = !StallD && !PCSrcE &&
                    (((state == S_WAIT) && ImemRspValid && !drop) || (state == S_HOLD));
    assign load_data_c = (state == S_HOLD) ? hold_data : ImemRspData;

    // Request sequencer and PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_REQ;
            pcf       <= RESET_PC;
            req_pc    <= '0;
            hold_data <= '0;
            drop      <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (PCSrcE) begin
                        pcf <= pc_target_c;
                    end else if (handshake_c) begin
                        req_pc <= pcf;
                        pcf    <= pcf + PC_STEP;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (PCSrcE) begin
                        pcf <= pc_target_c;
                    end
                    if (ImemRspValid) begin
                        drop <= 1'b0;
                        if (drop || PCSrcE || !StallD) begin
                            state <= S_REQ;
                        end else begin
                            hold_data <= ImemRspData;
                            state     <= S_HOLD;
                        end
                    end else if (PCSrcE) begin
                        // Response still owed for the old path; squash it on arrival.
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (PCSrcE) begin
                        pcf   <= pc_target_c;
                        state <= S_REQ;
                    end else if (!StallD) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // IF/ID register: flush beats stall beats load beats bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD) begin
            ValidD <= 1'b0;
            InstrD <= NOP;
        end else if (!StallD) begin
            if (load_c) begin
                ValidD   <= 1'b1;
                InstrD   <= load_data_c;
                PCD      <= req_pc;
                PCPlus4D <= req_pc + PC_STEP;
            end else begin
                ValidD <= 1'b0;
                InstrD <= NOP;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts words that actually land in IF/ID and decode-stall cycles holding a real instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrCount <= '0;
            StallCount <= '0;
        end else begin
            if (load_c && !FlushD) begin
                InstrCount <= InstrCount + XLEN'(1);
            end
            if (StallD && ValidD) begin
                StallCount <= StallCount + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus randomized stall/backpressure/latency
// traffic checked against an in-order delivery model of the instruction stream.
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Memory model state and handshake observations from the last step.
    logic        hs;
    logic        hs_pend;
    logic [31:0] hs_addr;
    logic        rsp_fire;
    logic        mem_pend;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;

    always #5 clk = ~clk;

    instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction

    // One clock: record the handshake seen before the edge, then play the memory side after it.
    task automatic step();
        #1;
        hs       = ImemReqValid && ImemReqReady;
        hs_addr  = ImemAddr;
        hs_pend  = mem_pend;
        rsp_fire = ImemRspValid;
        @(posedge clk);
        #1;
        if (rsp_fire) mem_pend = 1'b0;
        if (hs) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = hs_addr;
        end
        ImemRspValid = 1'b0;
        if (mem_pend) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                ImemRspValid = 1'b1;
                ImemRspData  = mem_word(mem_addr);
            end
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;
        ImemReqReady = 1'b0; ImemRspValid = 1'b0; ImemRspData = '0;
        mem_pend = 1'b0; mem_cnt = 0; mem_lat = 1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;
        ImemReqReady = 1'b1; ImemRspValid = 1'b0; ImemRspData = '0;
        mem_pend = 1'b0; mem_cnt = 0; mem_lat = 1;
        step();
        total_cnt++; if (ImemReqValid !== 1'b0) $display("FAIL rst_reqvalid: got %b exp 0", ImemReqValid); else pass_cnt++;
        step();
        total_cnt++; if (hs !== 1'b0) $display("FAIL rst_no_handshake: got %b exp 0", hs); else pass_cnt++;
        reset = 1'b0; ImemReqReady = 1'b0;
        #1;
        total_cnt++; if (ValidD !== 1'b0) $display("FAIL rst_validd: got %b exp 0", ValidD); else pass_cnt++;
        total_cnt++; if (InstrD !== NOP) $display("FAIL rst_instrd: got %h exp %h", InstrD, NOP); else pass_cnt++;
        total_cnt++; if (PCD !== 32'h0) $display("FAIL rst_pcd: got %h exp 0", PCD); else pass_cnt++;
        total_cnt++; if (PCPlus4D !== 32'h0) $display("FAIL rst_pcplus4d: got %h exp 0", PCPlus4D); else pass_cnt++;
        total_cnt++; if (ImemAddr !== RST_PC) $display("FAIL rst_addr: got %h exp %h", ImemAddr, RST_PC); else pass_cnt++;
        total_cnt++; if (ImemReqValid !== 1'b1) $display("FAIL rst_release_reqvalid: got %b exp 1", ImemReqValid); else pass_cnt++;
    endtask

    task automatic test_basic();
        mem_lat = 1; ImemReqReady = 1'b1;
        step();
        ImemReqReady = 1'b0;
        total_cnt++; if (ImemAddr !== 32'h1004) $display("FAIL basic_pc_adv: got %h exp 00001004", ImemAddr); else pass_cnt++;
        total_cnt++; if (ValidD !== 1'b0) $display("FAIL basic_not_yet: got %b exp 0", ValidD); else pass_cnt++;
        step();
        total_cnt++; if (InstrD !== 32'h0050_0093) $display("FAIL basic_instrd: got %h exp 00500093", InstrD); else pass_cnt++;
        total_cnt++; if (PCD !== 32'h1000) $display("FAIL basic_pcd: got %h exp 00001000", PCD); else pass_cnt++;
        total_cnt++; if (PCPlus4D !== 32'h1004) $display("FAIL basic_pcplus4d: got %h exp 00001004", PCPlus4D); else pass_cnt++;
        total_cnt++; if (ValidD !== 1'b1) $display("FAIL basic_validd: got %b exp 1", ValidD); else pass_cnt++;
        total_cnt++; if (ImemAddr !== 32'h1004) $display("FAIL basic_next_addr: got %h exp 00001004", ImemAddr); else pass_cnt++;
        step();
        total_cnt++; if (ValidD !== 1'b0) $display("FAIL basic_bubble: got %b exp 0", ValidD); else pass_cnt++;
        total_cnt++; if (InstrD !== NOP) $display("FAIL basic_bubble_nop: got %h exp %h", InstrD, NOP); else pass_cnt++;
    endtask

    task automatic test_stall();
        ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0; step();
        total_cnt++; if (PCD !== 32'h1004 || ValidD !== 1'b1) $display("FAIL stall_pre_load: got pcd=%h v=%b exp 00001004/1", PCD, ValidD); else pass_cnt++;
        StallD = 1'b1; ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++; if (PCD !== 32'h1004 || InstrD !== mem_word(32'h1004) || ValidD !== 1'b1)
                $display("FAIL stall_hold_%0d: got pcd=%h instr=%h v=%b exp 00001004/%h/1", k, PCD, InstrD, ValidD, mem_word(32'h1004));
            else pass_cnt++;
        end
        total_cnt++; if (ImemReqValid !== 1'b0) $display("FAIL stall_no_req_in_hold: got %b exp 0", ImemReqValid); else pass_cnt++;
        StallD = 1'b0; step();
        total_cnt++; if (PCD !== 32'h1008 || InstrD !== mem_word(32'h1008) || PCPlus4D !== 32'h100C || ValidD !== 1'b1)
            $display("FAIL stall_release_load: got pcd=%h instr=%h p4=%h v=%b exp 00001008/%h/0000100c/1", PCD, InstrD, PCPlus4D, ValidD, mem_word(32'h1008));
        else pass_cnt++;
        step();
        total_cnt++; if (ValidD !== 1'b0) $display("FAIL stall_once: got %b exp 0", ValidD); else pass_cnt++;
        total_cnt++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h100C)
            $display("FAIL stall_next_req: got v=%b addr=%h exp 1/0000100c", ImemReqValid, ImemAddr);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        mem_lat = 3; ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0;
        PCSrcE = 1'b1; PCTargetE = 32'h0000_2003; step(); PCSrcE = 1'b0;
        total_cnt++; if (ImemAddr !== 32'h2000) $display("FAIL redir_addr: got %h exp 00002000", ImemAddr); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step();
            total_cnt++; if (ValidD !== 1'b0) $display("FAIL redir_discard_%0d: got %b exp 0", k, ValidD); else pass_cnt++;
        end
        total_cnt++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h2000)
            $display("FAIL redir_next_req: got v=%b addr=%h exp 1/00002000", ImemReqValid, ImemAddr);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        mem_lat = 1; ImemReqReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total_cnt++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h2000)
                $display("FAIL bp_stable_%0d: got v=%b addr=%h exp 1/00002000", k, ImemReqValid, ImemAddr);
            else pass_cnt++;
            step();
        end
        ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0;
        total_cnt++; if (ImemAddr !== 32'h2004) $display("FAIL bp_advance: got %h exp 00002004", ImemAddr); else pass_cnt++;
        step();
        total_cnt++; if (PCD !== 32'h2000 || InstrD !== mem_word(32'h2000) || ValidD !== 1'b1)
            $display("FAIL bp_load: got pcd=%h instr=%h v=%b exp 00002000/%h/1", PCD, InstrD, ValidD, mem_word(32'h2000));
        else pass_cnt++;
    endtask

    task automatic test_flush();
        ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0; step();
        total_cnt++; if (PCD !== 32'h2004 || ValidD !== 1'b1) $display("FAIL flush_pre: got pcd=%h v=%b exp 00002004/1", PCD, ValidD); else pass_cnt++;
        StallD = 1'b1; FlushD = 1'b1; step(); StallD = 1'b0; FlushD = 1'b0;
        total_cnt++; if (ValidD !== 1'b0) $display("FAIL flush_validd: got %b exp 0", ValidD); else pass_cnt++;
        total_cnt++; if (InstrD !== NOP) $display("FAIL flush_instrd: got %h exp %h", InstrD, NOP); else pass_cnt++;
        total_cnt++; if (PCD !== 32'h2004) $display("FAIL flush_pcd_kept: got %h exp 00002004", PCD); else pass_cnt++;
    endtask

    task automatic test_wrap();
        mem_lat = 1; ImemReqReady = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
        #1;
        total_cnt++; if (ImemReqValid !== 1'b0) $display("FAIL wrap_redir_masks_req: got %b exp 0", ImemReqValid); else pass_cnt++;
        step(); PCSrcE = 1'b0;
        total_cnt++; if (hs !== 1'b0) $display("FAIL wrap_no_hs: got %b exp 0", hs); else pass_cnt++;
        total_cnt++; if (ImemAddr !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h exp fffffffc", ImemAddr); else pass_cnt++;
        step(); ImemReqReady = 1'b0;
        total_cnt++; if (ImemAddr !== 32'h0) $display("FAIL wrap_pcf: got %h exp 00000000", ImemAddr); else pass_cnt++;
        step();
        total_cnt++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || InstrD !== mem_word(32'hFFFF_FFFC) || ValidD !== 1'b1)
            $display("FAIL wrap_load: got pcd=%h p4=%h instr=%h v=%b exp fffffffc/00000000/%h/1", PCD, PCPlus4D, InstrD, ValidD, mem_word(32'hFFFF_FFFC));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        step();
        mem_lat = 4; ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        total_cnt++; if (ImemAddr !== RST_PC || ValidD !== 1'b0)
            $display("FAIL rmid_state: got addr=%h v=%b exp %h/0", ImemAddr, ValidD, RST_PC);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            step();
            total_cnt++; if (ValidD !== 1'b0 || ImemAddr !== RST_PC)
                $display("FAIL rmid_ignore_%0d: got v=%b addr=%h exp 0/%h", k, ValidD, ImemAddr, RST_PC);
            else pass_cnt++;
        end
        total_cnt++; if (ImemReqValid !== 1'b1) $display("FAIL rmid_reqvalid: got %b exp 1", ImemReqValid); else pass_cnt++;
        mem_lat = 1; ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0; step();
        total_cnt++; if (PCD !== RST_PC || InstrD !== 32'h0050_0093 || ValidD !== 1'b1)
            $display("FAIL rmid_refetch: got pcd=%h instr=%h v=%b exp %h/00500093/1", PCD, InstrD, ValidD, RST_PC);
        else pass_cnt++;
    endtask

    // Without redirects or flushes, decode must see every word exactly once in PC order.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        int          delivered;
        reset_dut();
        exp_pc = RST_PC; exp_req = RST_PC; delivered = 0;
        for (int i = 0; i < 600; i++) begin
            StallD       = ($urandom_range(0, 9) < 3);
            ImemReqReady = 1'($urandom_range(0, 1));
            mem_lat      = int'($urandom_range(1, 3));
            if (ValidD && !StallD) begin
                total_cnt++; if (PCD !== exp_pc || InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'd4)
                    $display("FAIL rand_deliver_%0d: got pcd=%h instr=%h p4=%h exp %h/%h/%h", i, PCD, InstrD, PCPlus4D, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                else pass_cnt++;
                exp_pc = exp_pc + 32'd4; delivered++;
            end
            step();
            if (hs) begin
                total_cnt++; if (hs_addr !== exp_req || hs_pend !== 1'b0)
                    $display("FAIL rand_request_%0d: got addr=%h outstanding=%b exp %h/0", i, hs_addr, hs_pend, exp_req);
                else pass_cnt++;
                exp_req = exp_req + 32'd4;
            end
        end
        StallD = 1'b0; ImemReqReady = 1'b0;
        total_cnt++; if (delivered < 20) $display("FAIL rand_progress: got %0d delivered exp >= 20", delivered); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
